si_arbiter: RTL

Round-robin arbiter that shares one Simple Interface (SI) write port between several requesters, such as the host command parser and on-chip auto-configuration logic. It sits directly in front of `conf_regs` and sequences one register write at a time onto the SI bus. Each write completes either on the slave's ack or on a bounded timeout, so a write to an unmapped address cannot hang the bus.

---
 rtl/si_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/si_arbiter.sv
// si_arbiter: round-robin arbiter sharing one Simple Interface (SI) write port
// between NUM_MASTERS requesters. It runs one register write at a time. Each write ends
// on s_ack or after TIMEOUT cycles of s_rdy, then spends one DONE cycle with s_rdy low.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   m_addr, m_data  packed requester address/data (requester i at slice i)
//   m_rdy           per-requester request strobe
//   m_ack, m_err    per-requester one-cycle completion pulses (accepted / timed out)
//   s_addr, s_data  SI address/data, held stable while s_rdy is high
//   s_rdy           SI data-ready strobe
//   s_ack           SI acknowledge (OR of all register acks)
//   grant           one-hot owner of the current transaction, 0 when idle
//   busy            high whenever a transaction is in ISSUE or DONE
module si_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data,
    input  logic [NUM_MASTERS-1:0]          m_rdy,
    output logic [NUM_MASTERS-1:0]          m_ack,
    output logic [NUM_MASTERS-1:0]          m_err,
    output logic [ADDR_WIDTH-1:0]           s_addr,
    output logic [DATA_WIDTH-1:0]           s_data,
    output logic                            s_rdy,
    input  logic                            s_ack,
    output logic [NUM_MASTERS-1:0]          grant,
    output logic                            busy
);

    localparam int unsigned PTR_W   = $clog2(NUM_MASTERS);
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e                      r_state;
    logic [PTR_W-1:0]            r_ptr;
    logic [7:0]                  r_cnt;
    logic [ADDR_WIDTH-1:0]       r_s_addr;
    logic [DATA_WIDTH-1:0]       r_s_data;
    logic                        r_s_rdy;
    logic [NUM_MASTERS-1:0]      r_grant;
    logic [NUM_MASTERS-1:0]      r_m_ack;
    logic [NUM_MASTERS-1:0]      r_m_err;

    logic                        w_found;
    int unsigned                 w_idx;
    logic [NUM_MASTERS-1:0]      w_sel_onehot;
    logic [ADDR_WIDTH-1:0]       w_sel_addr;
    logic [DATA_WIDTH-1:0]       w_sel_data;
    logic [PTR_W-1:0]            w_next_ptr;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] w_addr_shift;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] w_data_shift;

    // Scan requesters starting at r_ptr, wrapping around; first requester found wins.
    always_comb begin
        w_found      = 1'b0;
        w_idx        = 0;
        w_sel_onehot = '0;
        w_sel_addr   = '0;
        w_sel_data   = '0;
        w_next_ptr   = '0;
        w_addr_shift = '0;
        w_data_shift = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NUM_MASTERS) begin
                w_idx = w_idx - NUM_MASTERS;
            end
            if (!w_found && ((m_rdy >> w_idx) & 1) != '0) begin
                w_found      = 1'b1;
                w_sel_onehot = NUM_MASTERS'(1) << w_idx;
                w_addr_shift = m_addr >> (w_idx * ADDR_WIDTH);
                w_data_shift = m_data >> (w_idx * DATA_WIDTH);
                w_sel_addr   = w_addr_shift[ADDR_WIDTH-1:0];
                w_sel_data   = w_data_shift[DATA_WIDTH-1:0];
                w_next_ptr   = (w_idx == NUM_MASTERS - 1) ? '0 : PTR_W'(w_idx + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_s_addr <= '0;
            r_s_data <= '0;
            r_s_rdy  <= 1'b0;
            r_grant  <= '0;
            r_m_ack  <= '0;
            r_m_err  <= '0;
        end else begin
            // Completion pulses last exactly one cycle (the DONE cycle).
            r_m_ack <= '0;
            r_m_err <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_s_addr <= w_sel_addr;
                        r_s_data <= w_sel_data;
                        r_grant  <= w_sel_onehot;
                        r_ptr    <= w_next_ptr;
                        r_cnt    <= '0;
                        r_s_rdy  <= 1'b1;
                        r_state  <= StIssue;
                    end
                end
                StIssue: begin
                    r_cnt <= r_cnt + 8'd1;
                    // Ack takes precedence over a timeout in the same cycle.
                    if (s_ack) begin
                        r_m_ack <= r_grant;
                        r_s_rdy <= 1'b0;
                        r_state <= StDone;
                    end else if (r_cnt == TO_LAST) begin
                        r_m_err <= r_grant;
                        r_s_rdy <= 1'b0;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_grant <= '0;
                    r_state <= StIdle;
                end
                default: begin
                    r_s_rdy <= 1'b0;
                    r_grant <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign m_ack  = r_m_ack;
    assign m_err  = r_m_err;
    assign s_addr = r_s_addr;
    assign s_data = r_s_data;
    assign s_rdy  = r_s_rdy;
    assign grant  = r_grant;
    assign busy   = (r_state != StIdle);

endmodule
